lvt_write_tracker: RTL and testbench

LVT_WRITE_TRACKER -- requirements
Module: lvt_write_tracker

---
 rtl/lvt_write_tracker.sv | 82 ++++++++
 tb/tb_lvt_write_tracker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lvt_write_tracker.sv
// lvt_write_tracker: live-value table recording which write port last wrote each index.
// An INIT sweep zeroes the table after reset; RUN accepts up to four writes and two reads per cycle.
module lvt_write_tracker #(
    parameter int IDX_W = 6,
    parameter int NPORT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NPORT-1:0] wr_en,
    input  logic [IDX_W-1:0] wr_idx_0,
    input  logic [IDX_W-1:0] wr_idx_1,
    input  logic [IDX_W-1:0] wr_idx_2,
    input  logic [IDX_W-1:0] wr_idx_3,
    output logic             wr_ready,
    input  logic             rd_en_0,
    input  logic             rd_en_1,
    input  logic [IDX_W-1:0] rd_idx_0,
    input  logic [IDX_W-1:0] rd_idx_1,
    output logic [1:0]       rd_sel_0,
    output logic [1:0]       rd_sel_1,
    output logic             rd_valid_0,
    output logic             rd_valid_1,
    output logic [7:0]       drop_cnt
);
    localparam int DEPTH = 1 << IDX_W;
    typedef enum logic {INIT, RUN} state_t;
    state_t           state, state_nxt;
    logic [IDX_W-1:0] sweep, sweep_nxt;
    logic [1:0]       lvt [DEPTH];
    logic [IDX_W-1:0] wr_idx [NPORT];
    logic [8:0]       drop_sum;
    logic [7:0]       drop_nxt;
    assign wr_idx[0] = wr_idx_0;
    assign wr_idx[1] = wr_idx_1;
    assign wr_idx[2] = wr_idx_2;
    assign wr_idx[3] = wr_idx_3;
    assign wr_ready  = (state == RUN);
    always_comb begin
        state_nxt = state;
        sweep_nxt = sweep;
        drop_sum  = {1'b0, drop_cnt} + ((state == INIT) ? 9'($countones(wr_en)) : 9'd0);
        drop_nxt  = drop_sum[8] ? 8'hff : drop_sum[7:0];
        if (state == INIT) begin
            sweep_nxt = sweep + 1'b1;
            state_nxt = (sweep == IDX_W'(DEPTH - 1)) ? RUN : INIT;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= INIT;
            sweep    <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            sweep    <= sweep_nxt;
            drop_cnt <= drop_nxt;
        end
    end
    // Table is unreset; ascending loop order lets the highest port win on a shared index.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (state == INIT)
                lvt[sweep] <= 2'd0;
            else
                for (int p = 0; p < NPORT; p++)
                    if (wr_en[p]) lvt[wr_idx[p]] <= 2'(p);
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_0 <= 1'b0;
            rd_valid_1 <= 1'b0;
            rd_sel_0   <= 2'd0;
            rd_sel_1   <= 2'd0;
        end else begin
            rd_valid_0 <= rd_en_0;
            rd_valid_1 <= rd_en_1;
            if (rd_en_0) rd_sel_0 <= lvt[rd_idx_0];
            if (rd_en_1) rd_sel_1 <= lvt[rd_idx_1];
        end
    end
endmodule

// File: tb/tb_lvt_write_tracker.sv
// tb_lvt_write_tracker: randomized and directed checks of lvt_write_tracker against a behavioural table model.
module tb_lvt_write_tracker;
    logic       clk;
    logic       reset_n;
    logic [3:0] wr_en;
    logic [5:0] widx [4];
    logic       wr_ready;
    logic [1:0] ren;
    logic [5:0] ridx [2];
    logic [1:0] rd_sel_0, rd_sel_1;
    logic       rd_valid_0, rd_valid_1;
    logic [7:0] drop_cnt;
    int total = 0;
    int bad = 0;
    bit chk_on = 0;
    int tab [64];
    bit kn [64];
    int init_left = 64;
    int drops = 0;
    int msel [2] = '{0, 0};
    bit mkn [2] = '{1, 1};
    bit mval [2] = '{0, 0};

    lvt_write_tracker #(.IDX_W(6), .NPORT(4)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en),
        .wr_idx_0(widx[0]), .wr_idx_1(widx[1]), .wr_idx_2(widx[2]), .wr_idx_3(widx[3]),
        .wr_ready(wr_ready),
        .rd_en_0(ren[0]), .rd_en_1(ren[1]), .rd_idx_0(ridx[0]), .rd_idx_1(ridx[1]),
        .rd_sel_0(rd_sel_0), .rd_sel_1(rd_sel_1),
        .rd_valid_0(rd_valid_0), .rd_valid_1(rd_valid_1), .drop_cnt(drop_cnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Table semantics: reads see the old contents, the first 64 cycles after reset zero the table
    // in index order and discard writes, afterwards each strobed port stamps its number.
    task automatic model_step();
        if (!reset_n) begin
            init_left = 64;
            drops = 0;
            msel = '{0, 0};
            mkn = '{1, 1};
            mval = '{0, 0};
        end else begin
            for (int x = 0; x < 2; x++) begin
                mval[x] = ren[x];
                if (ren[x]) begin
                    msel[x] = tab[ridx[x]];
                    mkn[x] = kn[ridx[x]];
                end
            end
            if (init_left > 0) begin
                tab[64 - init_left] = 0;
                kn[64 - init_left] = 1;
                drops = drops + $countones(wr_en);
                if (drops > 255) drops = 255;
                init_left--;
            end else begin
                for (int p = 0; p < 4; p++)
                    if (wr_en[p]) begin
                        tab[widx[p]] = p;
                        kn[widx[p]] = 1;
                    end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            check("wr_ready", int'(wr_ready), int'(init_left == 0));
            check("rd_valid_0", int'(rd_valid_0), int'(mval[0]));
            check("rd_valid_1", int'(rd_valid_1), int'(mval[1]));
            if (mkn[0]) check("rd_sel_0", int'(rd_sel_0), msel[0]);
            if (mkn[1]) check("rd_sel_1", int'(rd_sel_1), msel[1]);
            check("drop_cnt", int'(drop_cnt), drops);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rnd(input bit narrow);
        wr_en = 4'($urandom);
        for (int p = 0; p < 4; p++) widx[p] = narrow ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
        ren = 2'($urandom);
        for (int x = 0; x < 2; x++) ridx[x] = ($urandom_range(0, 3) == 0) ? widx[0] : 6'($urandom_range(0, 63));
    endtask

    task automatic wait_ready(input string nm, input int exp);
        int n;
        n = 0;
        while (!wr_ready && n < 200) begin
            tick();
            n++;
        end
        check(nm, n, exp);
    endtask

    initial begin
        reset_n = 0;
        wr_en = 0;
        ren = 0;
        for (int p = 0; p < 4; p++) widx[p] = 0;
        ridx[0] = 0;
        ridx[1] = 0;
        repeat (3) tick();
        check("rst_ready", int'(wr_ready), 0);
        check("rst_valid0", int'(rd_valid_0), 0);
        check("rst_sel0", int'(rd_sel_0), 0);
        check("rst_drop", int'(drop_cnt), 0);
        chk_on = 1;
        wr_en = 4'b0001;
        reset_n = 1;
        wait_ready("sweep_len", 64);
        check("drop_64", int'(drop_cnt), 64);
        wr_en = 0;
        for (int i = 0; i < 64; i++) begin
            ren = 2'b11;
            ridx[0] = 6'(i);
            ridx[1] = 6'(63 - i);
            tick();
            if (i == 17) check("sweep_rd", int'(rd_sel_0), 0);
        end
        ren = 0;
        wr_en = 4'b0100;
        widx[2] = 5;
        tick();
        wr_en = 0;
        ren[0] = 1;
        ridx[0] = 5;
        tick();
        ren = 0;
        check("wr_rd_sel", int'(rd_sel_0), 2);
        check("wr_rd_valid", int'(rd_valid_0), 1);
        for (int p = 0; p < 4; p++) widx[p] = 9;
        wr_en = 4'b1011;
        tick();
        wr_en = 0;
        ren[0] = 1;
        ridx[0] = 9;
        tick();
        check("conflict_1011", int'(rd_sel_0), 3);
        ren = 0;
        wr_en = 4'b0011;
        tick();
        wr_en = 0;
        ren[0] = 1;
        tick();
        check("conflict_0011", int'(rd_sel_0), 1);
        ren = 0;
        wr_en = 4'b1000;
        widx[3] = 7;
        tick();
        wr_en = 4'b0010;
        widx[1] = 7;
        ren[1] = 1;
        ridx[1] = 7;
        tick();
        wr_en = 0;
        check("read_first_old", int'(rd_sel_1), 3);
        tick();
        check("read_first_new", int'(rd_sel_1), 1);
        ren = 0;
        tick();
        check("hold_valid1", int'(rd_valid_1), 0);
        check("hold_sel1", int'(rd_sel_1), 1);
        for (int i = 0; i < 3000; i++) begin
            rnd(i % 4 == 0);
            tick();
        end
        reset_n = 0;
        wr_en = 0;
        tick();
        reset_n = 1;
        wr_en = 4'b1111;
        ren = 2'b11;
        ridx[0] = 0;
        ridx[1] = 1;
        repeat (30) tick();
        reset_n = 0;
        #1;
        check("mid_rst_ready", int'(wr_ready), 0);
        check("mid_rst_valid0", int'(rd_valid_0), 0);
        check("mid_rst_valid1", int'(rd_valid_1), 0);
        check("mid_rst_sel0", int'(rd_sel_0), 0);
        check("mid_rst_sel1", int'(rd_sel_1), 0);
        check("mid_rst_drop", int'(drop_cnt), 0);
        tick();
        reset_n = 1;
        wait_ready("resweep_len", 64);
        check("drop_sat", int'(drop_cnt), 255);
        wr_en = 0;
        ren = 0;
        reset_n = 0;
        tick();
        reset_n = 1;
        for (int i = 0; i < 1500; i++) begin
            rnd(i % 3 == 0);
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
